axi_csr_bridge: RTL and testbench

AXI_CSR_BRIDGE -- requirements
Module: axi_csr_bridge

---
 rtl/ravenoc_pkg.sv | 68 ++++++
 rtl/axi_csr_bridge_if.sv | 13 +
 rtl/axi_csr_bridge.sv | 142 ++++++++++++++
 tb/tb_axi_csr_bridge.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// ravenoc_pkg: shared AXI slave-port and CSR types, response codes and bridge FSM states.
package ravenoc_pkg;
    localparam int AXI_ADDR_W   = 32;
    localparam int AXI_DATA_W   = 32;
    localparam int AXI_ID_W_MAX = 4;
    localparam int CSR_ADDR_W   = 16;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_REQ,
        RD_CAP,
        RD_RESP
    } axi_csr_st_t;

    typedef struct packed {
        logic [AXI_ID_W_MAX-1:0] aw_id;
        logic [AXI_ADDR_W-1:0]   aw_addr;
        logic [7:0]              aw_len;
        logic                    aw_valid;
        logic [AXI_DATA_W-1:0]   w_data;
        logic                    w_last;
        logic                    w_valid;
        logic                    b_ready;
        logic [AXI_ID_W_MAX-1:0] ar_id;
        logic [AXI_ADDR_W-1:0]   ar_addr;
        logic [7:0]              ar_len;
        logic                    ar_valid;
        logic                    r_ready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                    aw_ready;
        logic                    w_ready;
        logic [AXI_ID_W_MAX-1:0] b_id;
        logic [1:0]              b_resp;
        logic                    b_valid;
        logic                    ar_ready;
        logic [AXI_ID_W_MAX-1:0] r_id;
        logic [AXI_DATA_W-1:0]   r_data;
        logic [1:0]              r_resp;
        logic                    r_last;
        logic                    r_valid;
    } s_axi_miso_t;

    typedef struct packed {
        logic                  valid;
        logic                  rd_or_wr;
        logic [CSR_ADDR_W-1:0] addr;
        logic [AXI_DATA_W-1:0] data_in;
    } s_csr_req_t;

    typedef struct packed {
        logic                  ready;
        logic                  error;
        logic [AXI_DATA_W-1:0] data_out;
    } s_csr_resp_t;

    // INCR burst of 32-bit beats; the CSR space is 16 bits wide and wraps.
    function automatic logic [CSR_ADDR_W-1:0] csr_beat_addr(input logic [CSR_ADDR_W-1:0] base,
                                                            input logic [7:0] beat);
        return base + {6'd0, beat, 2'b00};
    endfunction
endpackage

// File: rtl/axi_csr_bridge_if.sv
// axi_csr_bridge_if: bundle of the AXI slave-port channels and the CSR request/response pair.
interface axi_csr_bridge_if;
    import ravenoc_pkg::*;

    s_axi_mosi_t axi_mosi;
    s_axi_miso_t axi_miso;
    s_csr_req_t  csr_req;
    s_csr_resp_t csr_resp;

    modport master (output axi_mosi, input axi_miso);
    modport slave  (input axi_mosi, input csr_resp, output axi_miso, output csr_req);
    modport csr    (input csr_req, output csr_resp);
endinterface

// File: rtl/axi_csr_bridge.sv
// axi_csr_bridge: AXI4 slave turning each burst beat into one CSR access (INCR, 32-bit beats).
module axi_csr_bridge
    import ravenoc_pkg::*;
#(
    parameter int AXI_ID_W  = 1,
    parameter int MAX_BURST = 8
) (
    input  logic        clk_axi,
    input  logic        arst_axi,
    input  s_axi_mosi_t axi_mosi_i,
    output s_axi_miso_t axi_miso_o,
    output s_csr_req_t  csr_req_o,
    input  s_csr_resp_t csr_resp_i
);
    axi_csr_st_t           state_q, state_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [CSR_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_err_q, rd_err_d;
    logic [AXI_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  burst_err_q, burst_err_d;
    logic                  last_wr_q, last_wr_d;
    logic                  served_q, served_d;
    logic                  grant_wr, grant_rd, w_rdy, w_hs;
    logic [7:0]            a_len;
    logic                  unused;

    // On a conflict the read wins until something has been served, then directions alternate.
    assign grant_wr = axi_mosi_i.aw_valid & (~axi_mosi_i.ar_valid | (served_q & ~last_wr_q));
    assign grant_rd = axi_mosi_i.ar_valid & ~grant_wr;
    assign a_len    = grant_wr ? axi_mosi_i.aw_len : axi_mosi_i.ar_len;
    assign unused   = ^{axi_mosi_i.aw_id, axi_mosi_i.ar_id, axi_mosi_i.aw_addr, axi_mosi_i.ar_addr};

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        wr_err_d    = wr_err_q;
        rd_err_d    = rd_err_q;
        rd_data_d   = rd_data_q;
        burst_err_d = burst_err_q;
        last_wr_d   = last_wr_q;
        served_d    = served_q;
        axi_miso_o  = '0;
        csr_req_o   = '0;
        w_rdy       = csr_resp_i.ready | burst_err_q;
        w_hs        = 1'b0;
        case (state_q)
            IDLE: begin
                axi_miso_o.aw_ready = grant_wr & ~arst_axi;
                axi_miso_o.ar_ready = grant_rd & ~arst_axi;
                if (grant_wr | grant_rd) begin
                    id_d        = grant_wr ? axi_mosi_i.aw_id[AXI_ID_W-1:0] : axi_mosi_i.ar_id[AXI_ID_W-1:0];
                    addr_d      = grant_wr ? axi_mosi_i.aw_addr[CSR_ADDR_W-1:0] : axi_mosi_i.ar_addr[CSR_ADDR_W-1:0];
                    len_d       = a_len;
                    burst_err_d = int'(a_len) >= MAX_BURST;
                    beat_d      = '0;
                    wr_err_d    = 1'b0;
                    last_wr_d   = grant_wr;
                    served_d    = 1'b1;
                    state_d     = grant_wr ? WR_DATA : RD_REQ;
                end
            end
            WR_DATA: begin
                axi_miso_o.w_ready = w_rdy;
                w_hs = axi_mosi_i.w_valid & w_rdy;
                if (w_hs & ~burst_err_q)
                    csr_req_o = '{valid: 1'b1, rd_or_wr: 1'b1, addr: csr_beat_addr(addr_q, beat_q),
                                  data_in: axi_mosi_i.w_data};
                if (w_hs) begin
                    wr_err_d = wr_err_q | burst_err_q | csr_resp_i.error;
                    beat_d   = beat_q + 8'd1;
                    state_d  = axi_mosi_i.w_last ? WR_RESP : WR_DATA;
                end
            end
            WR_RESP: begin
                axi_miso_o.b_valid = 1'b1;
                axi_miso_o.b_id    = AXI_ID_W_MAX'(id_q);
                axi_miso_o.b_resp  = wr_err_q ? AXI_SLVERR : AXI_OKAY;
                if (axi_mosi_i.b_ready)
                    state_d = IDLE;
            end
            RD_REQ: begin
                // Oversized bursts skip the CSR entirely and are answered with an error beat.
                if (~burst_err_q & csr_resp_i.ready)
                    csr_req_o = '{valid: 1'b1, rd_or_wr: 1'b0, addr: csr_beat_addr(addr_q, beat_q),
                                  data_in: '0};
                if (burst_err_q | csr_resp_i.ready)
                    state_d = RD_CAP;
            end
            RD_CAP: begin
                rd_data_d = burst_err_q ? '0 : csr_resp_i.data_out;
                rd_err_d  = burst_err_q | csr_resp_i.error;
                state_d   = RD_RESP;
            end
            RD_RESP: begin
                axi_miso_o.r_valid = 1'b1;
                axi_miso_o.r_id    = AXI_ID_W_MAX'(id_q);
                axi_miso_o.r_data  = rd_data_q;
                axi_miso_o.r_resp  = rd_err_q ? AXI_SLVERR : AXI_OKAY;
                axi_miso_o.r_last  = beat_q == len_q;
                if (axi_mosi_i.r_ready) begin
                    beat_d  = beat_q + 8'd1;
                    state_d = (beat_q == len_q) ? IDLE : RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            state_q     <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            wr_err_q    <= 1'b0;
            rd_err_q    <= 1'b0;
            rd_data_q   <= '0;
            burst_err_q <= 1'b0;
            last_wr_q   <= 1'b0;
            served_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            wr_err_q    <= wr_err_d;
            rd_err_q    <= rd_err_d;
            rd_data_q   <= rd_data_d;
            burst_err_q <= burst_err_d;
            last_wr_q   <= last_wr_d;
            served_q    <= served_d;
        end
    end
endmodule

// File: tb/tb_axi_csr_bridge.sv
// tb_axi_csr_bridge: directed AXI bursts against a small CSR model with hand-computed expectations.
module tb_axi_csr_bridge;
    import ravenoc_pkg::*;

    logic        clk_axi  = 1'b0;
    logic        arst_axi = 1'b1;
    logic        csr_ready = 1'b1;
    logic        csr_err   = 1'b0;
    logic [31:0] csr_rdata = '0;
    s_axi_mosi_t m = '0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] log_addr[$];
    logic        log_wr[$];
    logic [31:0] log_data[$];

    axi_csr_bridge_if bus ();

    assign bus.axi_mosi = m;
    assign bus.csr_resp = '{ready: csr_ready, error: csr_err, data_out: csr_rdata};

    axi_csr_bridge dut (
        .clk_axi   (clk_axi),
        .arst_axi  (arst_axi),
        .axi_mosi_i(bus.axi_mosi),
        .axi_miso_o(bus.axi_miso),
        .csr_req_o (bus.csr_req),
        .csr_resp_i(bus.csr_resp)
    );

    always #5 clk_axi = ~clk_axi;

    // CSR model: logs every request, read data appears one cycle later.
    always @(posedge clk_axi) begin
        if (bus.csr_req.valid) begin
            log_addr.push_back(bus.csr_req.addr);
            log_wr.push_back(bus.csr_req.rd_or_wr);
            log_data.push_back(bus.csr_req.data_in);
            if (!bus.csr_req.rd_or_wr)
                csr_rdata <= 32'hA500_0000 | 32'(bus.csr_req.addr);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_axi);
        #1;
    endtask

    task automatic addr_phase(input logic is_wr, input logic [31:0] addr, input logic [7:0] len,
                              input logic [3:0] id);
        if (is_wr) begin
            m.aw_valid = 1'b1; m.aw_addr = addr; m.aw_len = len; m.aw_id = id;
        end else begin
            m.ar_valid = 1'b1; m.ar_addr = addr; m.ar_len = len; m.ar_id = id;
        end
        #1;
        for (int t = 0; t < 20 && !(is_wr ? bus.axi_miso.aw_ready : bus.axi_miso.ar_ready); t++)
            step();
        if (is_wr) chk("aw_ready", 64'(bus.axi_miso.aw_ready), 64'(1));
        else       chk("ar_ready", 64'(bus.axi_miso.ar_ready), 64'(1));
        step();
        if (is_wr) m.aw_valid = 1'b0;
        else       m.ar_valid = 1'b0;
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [31:0] d0, input int err_beat);
        for (int i = 0; i <= int'(len); i++) begin
            m.w_valid = 1'b1;
            m.w_data  = d0 + 32'(i);
            m.w_last  = (i == int'(len));
            csr_err   = (i == err_beat);
            #1;
            for (int t = 0; t < 20 && !bus.axi_miso.w_ready; t++)
                step();
            chk("w_ready", 64'(bus.axi_miso.w_ready), 64'(1));
            step();
        end
        m.w_valid = 1'b0;
        m.w_last  = 1'b0;
        csr_err   = 1'b0;
    endtask

    task automatic b_phase(input string tag, input logic [1:0] exp_resp, input logic [3:0] exp_id);
        s_axi_miso_t hold;
        for (int t = 0; t < 20 && !bus.axi_miso.b_valid; t++)
            step();
        chk({tag, "_bvalid"}, 64'(bus.axi_miso.b_valid), 64'(1));
        hold = bus.axi_miso;
        step();
        chk({tag, "_bhold"}, 64'(bus.axi_miso), 64'(hold));
        chk({tag, "_bresp"}, 64'(bus.axi_miso.b_resp), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(bus.axi_miso.b_id), 64'(exp_id));
        m.b_ready = 1'b1;
        step();
        m.b_ready = 1'b0;
        chk({tag, "_bdone"}, 64'(bus.axi_miso.b_valid), 64'(0));
    endtask

    task automatic r_phase(input string tag, input logic [15:0] base, input logic [7:0] len,
                           input logic [3:0] exp_id, input logic exp_err);
        s_axi_miso_t hold;
        logic [15:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 16'(4 * i);
            for (int t = 0; t < 20 && !bus.axi_miso.r_valid; t++)
                step();
            chk({tag, "_rvalid"}, 64'(bus.axi_miso.r_valid), 64'(1));
            hold = bus.axi_miso;
            step();
            chk({tag, "_rhold"}, 64'(bus.axi_miso), 64'(hold));
            if (!exp_err)
                chk({tag, "_rdata"}, 64'(bus.axi_miso.r_data), 64'(32'hA500_0000 | 32'(a)));
            chk({tag, "_rresp"}, 64'(bus.axi_miso.r_resp), 64'(exp_err ? AXI_SLVERR : AXI_OKAY));
            chk({tag, "_rlast"}, 64'(bus.axi_miso.r_last), 64'(i == int'(len)));
            chk({tag, "_rid"}, 64'(bus.axi_miso.r_id), 64'(exp_id));
            m.r_ready = 1'b1;
            step();
            m.r_ready = 1'b0;
        end
        chk({tag, "_rdone"}, 64'(bus.axi_miso.r_valid), 64'(0));
    endtask

    task automatic chk_log(input string tag, input int n, input logic [15:0] base, input logic wr,
                           input logic [31:0] d0);
        logic [15:0] a;
        chk({tag, "_ncsr"}, 64'(log_addr.size()), 64'(n));
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            a = base + 16'(4 * i);
            chk({tag, "_caddr"}, 64'(log_addr[i]), 64'(a));
            chk({tag, "_crw"}, 64'(log_wr[i]), 64'(wr));
            if (wr) chk({tag, "_cdata"}, 64'(log_data[i]), 64'(d0 + 32'(i)));
        end
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic seen;
        m.aw_valid = 1'b1;
        m.ar_valid = 1'b1;
        repeat (2) @(posedge clk_axi);
        #1;
        chk("rst_miso", 64'(bus.axi_miso), 64'(0));
        chk("rst_csr", 64'(bus.csr_req), 64'(0));
        m = '0;
        arst_axi = 1'b0;
        step();

        addr_phase(1'b1, 32'h0000_1014, 8'd0, 4'd1);
        w_phase(8'd0, 32'h3, -1);
        b_phase("wr1", AXI_OKAY, 4'd1);
        chk_log("wr1", 1, 16'h1014, 1'b1, 32'h3);

        addr_phase(1'b0, 32'h0000_1000, 8'd0, 4'd0);
        r_phase("rd1", 16'h1000, 8'd0, 4'd0, 1'b0);
        chk_log("rd1", 1, 16'h1000, 1'b0, 32'h0);

        addr_phase(1'b0, 32'h0000_1000, 8'd3, 4'd1);
        r_phase("rd4", 16'h1000, 8'd3, 4'd1, 1'b0);
        chk_log("rd4", 4, 16'h1000, 1'b0, 32'h0);

        addr_phase(1'b1, 32'h0000_0FFC, 8'd1, 4'd0);
        w_phase(8'd1, 32'hAA, 1);
        b_phase("wrerr", AXI_SLVERR, 4'd0);
        chk_log("wrerr", 2, 16'h0FFC, 1'b1, 32'hAA);

        addr_phase(1'b0, 32'h0001_FFFC, 8'd1, 4'd0);
        r_phase("wrap", 16'hFFFC, 8'd1, 4'd0, 1'b0);
        chk_log("wrap", 2, 16'hFFFC, 1'b0, 32'h0);

        addr_phase(1'b0, 32'h0000_2000, 8'd7, 4'd0);
        r_phase("maxrd", 16'h2000, 8'd7, 4'd0, 1'b0);
        chk_log("maxrd", 8, 16'h2000, 1'b0, 32'h0);

        addr_phase(1'b0, 32'h0000_1000, 8'd8, 4'd1);
        r_phase("longrd", 16'h1000, 8'd8, 4'd1, 1'b1);
        chk_log("longrd", 0, 16'h1000, 1'b0, 32'h0);

        addr_phase(1'b1, 32'h0000_1000, 8'd8, 4'd1);
        w_phase(8'd8, 32'h0, -1);
        b_phase("longwr", AXI_SLVERR, 4'd1);
        chk_log("longwr", 0, 16'h1000, 1'b1, 32'h0);

        csr_ready = 1'b0;
        addr_phase(1'b0, 32'h0000_1010, 8'd0, 4'd0);
        repeat (4) step();
        chk("stall_ncsr", 64'(log_addr.size()), 64'(0));
        chk("stall_rvalid", 64'(bus.axi_miso.r_valid), 64'(0));
        csr_ready = 1'b1;
        r_phase("stall", 16'h1010, 8'd0, 4'd0, 1'b0);
        chk_log("stall", 1, 16'h1010, 1'b0, 32'h0);

        arst_axi = 1'b1;
        step();
        arst_axi = 1'b0;
        step();
        m.aw_valid = 1'b1; m.aw_addr = 32'h0000_1018; m.aw_len = 8'd0; m.aw_id = 4'd1;
        m.ar_valid = 1'b1; m.ar_addr = 32'h0000_1004; m.ar_len = 8'd0; m.ar_id = 4'd0;
        #1;
        chk("arb1_ar", 64'(bus.axi_miso.ar_ready), 64'(1));
        chk("arb1_aw", 64'(bus.axi_miso.aw_ready), 64'(0));
        step();
        m.ar_addr = 32'h0000_1008;
        r_phase("arb1", 16'h1004, 8'd0, 4'd0, 1'b0);
        chk("arb2_aw", 64'(bus.axi_miso.aw_ready), 64'(1));
        chk("arb2_ar", 64'(bus.axi_miso.ar_ready), 64'(0));
        step();
        m.aw_valid = 1'b0;
        w_phase(8'd0, 32'h55, -1);
        b_phase("arb2", AXI_OKAY, 4'd1);
        addr_phase(1'b0, 32'h0000_1008, 8'd0, 4'd0);
        r_phase("arb3", 16'h1008, 8'd0, 4'd0, 1'b0);
        chk("arb_ncsr", 64'(log_addr.size()), 64'(3));
        if (log_addr.size() == 3) begin
            chk("arb_c0", 64'({log_wr[0], log_addr[0]}), 64'({1'b0, 16'h1004}));
            chk("arb_c1", 64'({log_wr[1], log_addr[1]}), 64'({1'b1, 16'h1018}));
            chk("arb_c2", 64'({log_wr[2], log_addr[2]}), 64'({1'b0, 16'h1008}));
        end
        log_addr.delete();
        log_wr.delete();
        log_data.delete();

        addr_phase(1'b0, 32'h0000_1000, 8'd3, 4'd1);
        for (int t = 0; t < 20 && !bus.axi_miso.r_valid; t++)
            step();
        chk("mid_b1_rdata", 64'(bus.axi_miso.r_data), 64'(32'hA500_1000));
        m.r_ready = 1'b1;
        step();
        m.r_ready = 1'b0;
        step();
        arst_axi = 1'b1;
        #1;
        chk("mid_rst_miso", 64'(bus.axi_miso), 64'(0));
        chk("mid_rst_csr", 64'(bus.csr_req), 64'(0));
        step();
        arst_axi = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | bus.axi_miso.r_valid;
        end
        chk("mid_no_rvalid", 64'(seen), 64'(0));
        log_addr.delete();
        log_wr.delete();
        log_data.delete();
        addr_phase(1'b0, 32'h0000_1004, 8'd0, 4'd1);
        r_phase("postrst", 16'h1004, 8'd0, 4'd1, 1'b0);
        chk_log("postrst", 1, 16'h1004, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
